da_fir_serial: RTL and testbench

Parametrised bit-serial distributed-arithmetic (DA) FIR filter. It is the successor to the fixed 8-bit DA filter. Tap count, data width and signed coefficient set are generic. A valid/ready handshake, a synchronous flush and a full-precision registered output are added. Each accepted sample enters a tap delay line, and y = sum c_i*x_i is evaluated LSB-first over DATA_W cycles through a 2^TAPS-entry partial-sum LUT.

---
 rtl/da_pkg.sv | 20 ++
 rtl/da_lut.sv | 16 +
 rtl/da_fir_serial.sv | 72 +++++++
 tb/tb_da_fir_serial.sv | 132 +++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// da_pkg: shared state encoding and elaboration-time helpers for the DA FIR filter
package da_pkg;
  typedef enum logic {IDLE, CALC} state_t;
  localparam int COEF_MAX = 512;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
  function automatic longint lut_entry(input logic [COEF_MAX-1:0] coefs, input int taps, input int coef_w, input int addr);
    longint s = 0;
    for (int i = 0; i < taps; i++) begin
      longint c = 0;
      for (int j = 0; j < coef_w; j++) c[j] = coefs[i*coef_w+j];
      if (c[coef_w-1]) c -= longint'(1) << coef_w;
      if (addr[i]) s += c;
    end
    return s;
  endfunction
endpackage

// File: rtl/da_lut.sv
// da_lut: combinational partial-sum ROM, entry a = sum of coefficients selected by bits of a
module da_lut import da_pkg::*; #(
  parameter int TAPS = 7,
  parameter int COEF_W = 8,
  parameter logic [TAPS*COEF_W-1:0] COEFS = '0,
  localparam int LUT_W = COEF_W + clog2(TAPS)
) (
  input  logic [TAPS-1:0]         addr,
  output logic signed [LUT_W-1:0] psum
);
  logic signed [LUT_W-1:0] rom [2**TAPS];
  for (genvar a = 0; a < 2**TAPS; a++) begin : g_rom
    assign rom[a] = LUT_W'(lut_entry(COEF_MAX'(COEFS), TAPS, COEF_W, a));
  end
  assign psum = rom[addr];
endmodule

// File: rtl/da_fir_serial.sv
// da_fir_serial: bit-serial distributed-arithmetic FIR, one result per DATA_W+1 cycles
module da_fir_serial import da_pkg::*; #(
  parameter int TAPS = 7,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter logic [TAPS*COEF_W-1:0] COEFS = {8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd3, 8'sd2, 8'sd1},
  localparam int OUT_W = DATA_W + COEF_W + clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       x_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] y_out,
  output logic                    out_valid
);
  localparam int LUT_W = COEF_W + clog2(TAPS);
  localparam int BW = clog2(DATA_W) < 1 ? 1 : clog2(DATA_W);
  state_t state, state_n;
  logic [DATA_W-1:0] dl [TAPS];
  logic [TAPS-1:0] addr;
  logic signed [LUT_W-1:0] psum;
  logic signed [OUT_W-1:0] acc, acc_n, term;
  logic [BW-1:0] bit_cnt;
  logic last;
  for (genvar t = 0; t < TAPS; t++) begin : g_addr
    assign addr[t] = dl[t][bit_cnt];
  end
  da_lut #(.TAPS(TAPS), .COEF_W(COEF_W), .COEFS(COEFS)) u_lut (.addr(addr), .psum(psum));
  // sign bit of two's complement carries negative weight, hence the subtraction on the last bit
  always_comb begin
    last = bit_cnt == BW'(DATA_W - 1);
    term = OUT_W'(psum) <<< bit_cnt;
    acc_n = last ? acc - term : acc + term;
    in_ready = state == IDLE;
    state_n = state == IDLE ? (in_valid ? CALC : IDLE) : (last ? IDLE : CALC);
  end
  always_ff @(posedge clk)
    state <= (!rst || clr) ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!rst) begin
      dl <= '{default: '0};
      acc <= '0;
      bit_cnt <= '0;
      y_out <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      dl <= '{default: '0};
      acc <= '0;
      bit_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (in_valid) begin
          dl[0] <= x_in;
          for (int i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
          acc <= '0;
          bit_cnt <= '0;
        end
      end else begin
        acc <= acc_n;
        bit_cnt <= bit_cnt + 1'b1;
        if (last) begin
          y_out <= acc_n;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_da_fir_serial.sv
// tb_da_fir_serial: directed vector bench for da_fir_serial (default and all -128 coefficient sets)
module tb_da_fir_serial;
  logic clk = 0, rst = 0, clr = 0, in_valid = 0;
  logic [7:0] x_in = '0;
  logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic signed [18:0] y_a, y_b;
  int checks = 0, failures = 0;
  typedef struct {bit rst_first; bit sel; int x; int y;} vec_t;
  vec_t vec[$];
  always #5 clk = ~clk;
  da_fir_serial dut_a (.clk(clk), .rst(rst), .clr(clr), .x_in(x_in), .in_valid(in_valid),
                       .in_ready(in_ready_a), .y_out(y_a), .out_valid(out_valid_a));
  da_fir_serial #(.COEFS({7{8'h80}})) dut_b (.clk(clk), .rst(rst), .clr(clr), .x_in(x_in), .in_valid(in_valid),
                       .in_ready(in_ready_b), .y_out(y_b), .out_valid(out_valid_b));
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 0;
    in_valid = 0;
    clr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask
  task automatic accept(input int x);
    int w = 0;
    while (!in_ready_a && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) chk("accept_timeout", w, 0);
    in_valid = 1;
    x_in = 8'(x);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic do_sample(input int x, input int ye, input bit sel, input string nm);
    int cnt = 0;
    accept(x);
    while (!in_ready_a && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    chk({nm, "_busy"}, cnt, 8);
    chk({nm, "_valid"}, sel ? out_valid_b : out_valid_a, 1);
    chk(nm, sel ? y_b : y_a, ye);
  endtask
  task automatic stream(input int x, input int ye, input bit sel, input string nm);
    int cyc = 0, n_acc = 0, n_out = 0, last_acc = 0;
    bit drop;
    do_reset();
    in_valid = 1;
    x_in = 8'(x);
    while (n_out < 8 && cyc < 200) begin
      drop = 0;
      if (in_ready_a && in_valid) begin
        if (n_acc > 0) chk({nm, "_gap"}, cyc - last_acc, 9);
        last_acc = cyc;
        n_acc++;
        drop = n_acc == 8;
      end
      @(posedge clk); #1; cyc++;
      if (drop) in_valid = 0;
      if (out_valid_a) begin
        n_out++;
        if (n_out >= 7) chk(nm, sel ? y_b : y_a, ye);
      end
    end
    in_valid = 0;
    chk({nm, "_outs"}, n_out, 8);
  endtask
  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (vec[i].rst_first) do_reset();
      do_sample(vec[i].x, vec[i].y, vec[i].sel, $sformatf("vec%0d", i));
    end
  endtask
  initial begin
    int imp[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    int seen;
    for (int i = 0; i < 8; i++) vec.push_back('{i == 0, 0, i == 0 ? 1 : 0, imp[i]});
    for (int i = 0; i < 8; i++) vec.push_back('{i == 0, 0, i == 0 ? -1 : 0, -imp[i]});
    for (int k = 1; k <= 7; k++) vec.push_back('{k == 1, 1, -128, k * 16384});
    for (int k = 1; k <= 7; k++) vec.push_back('{0, 1, 127, -128 * (k * 127 - (7 - k) * 128)});
    do_reset();
    chk("rst_y", y_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_ready", in_ready_a, 1);
    run_vec(0, vec.size());
    stream(127, 2032, 0, "str_pos");
    stream(-128, -2048, 0, "str_neg");
    do_reset();
    do_sample(1, 1, 0, "clr_s0");
    do_sample(0, 2, 0, "clr_s1");
    do_sample(0, 3, 0, "clr_s2");
    accept(0);
    repeat (3) begin @(posedge clk); #1; end
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid_a) seen++;
      @(posedge clk); #1;
    end
    chk("clr_no_valid", seen, 0);
    chk("clr_y_hold", y_a, 3);
    chk("clr_ready", in_ready_a, 1);
    do_sample(0, 0, 0, "clr_flushed");
    do_reset();
    do_sample(1, 1, 0, "rst_mid_s0");
    accept(0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    chk("rst_mid_valid", out_valid_a, 0);
    chk("rst_mid_y", y_a, 0);
    chk("rst_mid_ready", in_ready_a, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid_a) seen++;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_valid", seen, 0);
    for (int i = 0; i < 8; i++) do_sample(i == 0 ? 1 : 0, imp[i], 0, $sformatf("rst_imp%0d", i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
